// File: rtl/alu_shift_pkg.sv
// Shared types and default widths for the shift-unit family (left sequential, right combinational).
package alu_shift_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_shift_left_seq.sv
// Sequential logical left shifter: one bit per clock, single-cycle done pulse, back-to-back restarts.
// Optional macro ALU_SHL_ROTATE_EN adds i_rot to select rotate-left instead of zero fill.
module alu_shift_left_seq
  import alu_shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [DATA_W-1:0]  i_a,
  input  logic [SHAMT_W-1:0] i_b,
`ifdef ALU_SHL_ROTATE_EN
  input  logic               i_rot,
`endif
  output logic               o_busy,
  output logic               o_done,
  output logic [DATA_W-1:0]  o_sll
);

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fill_s;
`ifdef ALU_SHL_ROTATE_EN
  logic                 rot_q, rot_d;
`endif

  // Bit entering position 0 on each step: wrapped MSB when rotating, otherwise zero.
  always_comb begin
`ifdef ALU_SHL_ROTATE_EN
    if (rot_q) begin
      fill_s = data_q[DATA_W-1];
    end else begin
      fill_s = 1'b0;
    end
`else
    fill_s = 1'b0;
`endif
  end

  // Next-state and datapath update; starts are honoured only from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef ALU_SHL_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          data_d = i_a;
          cnt_d  = i_b;
`ifdef ALU_SHL_ROTATE_EN
          rot_d  = i_rot;
`endif
          if (i_b == {SHAMT_W{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        data_d = {data_q[DATA_W-2:0], fill_s};
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output flags, cleared asynchronously by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      data_q  <= {DATA_W{1'b0}};
      cnt_q   <= {SHAMT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_SHL_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ALU_SHL_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_sll  = data_q;

endmodule

// File: tb/tb_alu_shift_left_seq.sv
// Directed and random self-checking bench for alu_shift_left_seq.
module tb_alu_shift_left_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [31:0] i_a;
  logic [4:0]  i_b;
  logic        i_rot_s;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_sll;

  int n_checks = 0;
  int n_fail   = 0;

  alu_shift_left_seq #(.DATA_W(32), .SHAMT_W(5)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
`ifdef ALU_SHL_ROTATE_EN
    .i_rot   (i_rot_s),
`endif
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_sll   (o_sll)
  );

  always #5 i_clk = ~i_clk;

  // Issue one start and wait (bounded) for o_done; edges counts edges after the accepting edge.
  task automatic do_op(input logic [31:0] a, input logic [4:0] b, input logic rot,
                       output int edges, output int busy_cnt, output bit overlap);
    @(negedge i_clk);
    i_start = 1'b1; i_a = a; i_b = b; i_rot_s = rot;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    edges = 0; busy_cnt = 0; overlap = 1'b0;
    while (!o_done && edges < 40) begin
      if (o_busy) busy_cnt++;
      @(posedge i_clk); #1;
      edges++;
    end
    if (o_busy && o_done) overlap = 1'b1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_a = 32'd0; i_b = 5'd0; i_rot_s = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    n_checks++;
    if ({o_busy, o_done, o_sll} !== 34'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", {o_busy, o_done, o_sll});
    end
    @(negedge i_clk); i_rst = 1'b0;
  endtask

  task automatic test_max_shift();
    int e, bc; bit ov;
    do_op(32'h0000_0001, 5'd31, 1'b0, e, bc, ov);
    n_checks++;
    if (e !== 31) begin n_fail++; $display("FAIL max_latency: got %0d required 31", e); end
    n_checks++;
    if (bc !== 31) begin n_fail++; $display("FAIL max_busy_cycles: got %0d required 31", bc); end
    n_checks++;
    if (o_sll !== 32'h8000_0000) begin n_fail++; $display("FAIL max_result: got %h required 80000000", o_sll); end
    n_checks++;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL max_busy_done_overlap: got %0d required 0", ov); end
  endtask

  task automatic test_zero_shift();
    int e, bc; bit ov;
    do_op(32'h1234_5678, 5'd0, 1'b0, e, bc, ov);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL zero_latency: got %0d required 0", e); end
    n_checks++;
    if (bc !== 0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %0d required 0", bc); end
    n_checks++;
    if (o_sll !== 32'h1234_5678) begin n_fail++; $display("FAIL zero_result: got %h required 12345678", o_sll); end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_done !== 1'b0 || o_sll !== 32'h1234_5678) begin
      n_fail++; $display("FAIL zero_idle_hold: got done=%b sll=%h required done=0 sll=12345678", o_done, o_sll);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    @(negedge i_clk);
    i_start = 1'b1; i_a = 32'hFFFF_FFFF; i_b = 5'd4;
    @(posedge i_clk); #1;
    // Start during SHIFT must be ignored.
    i_a = 32'h0; i_b = 5'd1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    e = 1;
    while (!o_done && e < 40) begin @(posedge i_clk); #1; e++; end
    n_checks++;
    if (e !== 4) begin n_fail++; $display("FAIL b2b_first_latency: got %0d required 4", e); end
    n_checks++;
    if (o_sll !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL b2b_ignore_result: got %h required fffffff0", o_sll); end
    i_start = 1'b1; i_a = 32'h3; i_b = 5'd1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_restart_busy: got busy=%b done=%b required busy=1 done=0", o_busy, o_done);
    end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_done !== 1'b1 || o_sll !== 32'h6) begin
      n_fail++; $display("FAIL b2b_second_result: got done=%b sll=%h required done=1 sll=6", o_done, o_sll);
    end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_sll !== 32'h6) begin
      n_fail++; $display("FAIL b2b_idle_hold: got done=%b busy=%b sll=%h required 0 0 6", o_done, o_busy, o_sll);
    end
  endtask

  task automatic test_reset_abort();
    int e, bc; bit ov, saw_done;
    @(negedge i_clk);
    i_start = 1'b1; i_a = 32'hA5A5_A5A5; i_b = 5'd8;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (2) @(posedge i_clk);
    #2; i_rst = 1'b1; #1;
    n_checks++;
    if ({o_busy, o_done, o_sll} !== 34'd0) begin
      n_fail++; $display("FAIL abort_async_clear: got %h required 0", {o_busy, o_done, o_sll});
    end
    @(negedge i_clk); i_rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin @(posedge i_clk); #1; if (o_done) saw_done = 1'b1; end
    n_checks++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b required 0", saw_done); end
    do_op(32'hA5A5_A5A5, 5'd8, 1'b0, e, bc, ov);
    n_checks++;
    if (e !== 8 || o_sll !== 32'hA5A5_A500) begin
      n_fail++; $display("FAIL abort_fresh_start: got edges=%0d sll=%h required edges=8 sll=a5a5a500", e, o_sll);
    end
  endtask

`ifdef ALU_SHL_ROTATE_EN
  task automatic test_rotate();
    int e, bc; bit ov;
    do_op(32'h8000_0001, 5'd1, 1'b1, e, bc, ov);
    n_checks++;
    if (o_sll !== 32'h0000_0003) begin n_fail++; $display("FAIL rotate_on: got %h required 00000003", o_sll); end
    do_op(32'h8000_0001, 5'd1, 1'b0, e, bc, ov);
    n_checks++;
    if (o_sll !== 32'h0000_0002) begin n_fail++; $display("FAIL rotate_off: got %h required 00000002", o_sll); end
  endtask
`endif

  task automatic test_random();
    int e, bc; bit ov;
    logic [31:0] a, exp_v;
    logic [4:0]  b;
    for (int k = 0; k < 1000; k++) begin
      a = $urandom;
      b = 5'($urandom_range(31, 0));
      exp_v = a << b;
      do_op(a, b, 1'b0, e, bc, ov);
      n_checks++;
      if (o_sll !== exp_v || e !== int'(b) || ov !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h b=%0d got sll=%h edges=%0d overlap=%b required sll=%h edges=%0d overlap=0",
                 k, a, b, o_sll, e, ov, exp_v, b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_max_shift();
    test_zero_shift();
    test_back_to_back();
    test_reset_abort();
`ifdef ALU_SHL_ROTATE_EN
    test_rotate();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
